multiclock_stim_ctrl: RTL

MULTICLOCK_STIM_CTRL -- requirements
Module: multiclock_stim_ctrl

---
 rtl/multiclock_stim_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/multiclock_stim_ctrl.sv
// -----------------------------------------------------------------------------
// multiclock_stim_ctrl
//
// Stimulus/response controller for a multiclock datapath under test. On an
// accepted start it drives num_vec pseudo-random 3-bit vectors (from a 16-bit
// Fibonacci LFSR) onto dut_in. It then flushes the datapath with DRAIN_CYC
// zero vectors and pulses done. Every response on dut_out seen while vectors
// or flush cycles are applied is compacted into a 16-bit MISR signature.
//
// Ports
//   clk        in   1       single clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   start      in   1       run request, level-sampled, honoured only in IDLE
//   num_vec    in   CNT_W   vectors to apply, latched on an accepted start
//   pause      in   1       freezes vector generation while in RUN
//   dut_out    in   3       {out3,out2,out1} from the datapath
//   dut_in     out  3       {in3,in2,in1} to the datapath, registered
//   busy       out  1       high in RUN, DRAIN and DONE
//   done       out  1       single-cycle completion pulse
//   vec_cnt    out  CNT_W   vectors applied in the current or last run
//   signature  out  16      MISR compaction of dut_out
// -----------------------------------------------------------------------------
module multiclock_stim_ctrl #(
   parameter int          CNT_W     = 16,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int          DRAIN_CYC = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_vec,
   input  logic             pause,
   input  logic [2:0]       dut_out,
   output logic [2:0]       dut_in,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] vec_cnt,
   output logic [15:0]      signature
);

   // Drain counter is wide enough to hold DRAIN_CYC-1 (at least one bit).
   localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t           state;
   logic [15:0]      lfsr;
   logic [CNT_W-1:0] num_lat;
   logic [DW-1:0]    drain_cnt;

   // The LFSR and the MISR share the same feedback taps (15,13,12,10).
   function automatic logic [15:0] shift16(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   logic [15:0] lfsr_nxt;
   logic [15:0] sig_nxt;

   assign lfsr_nxt = shift16(lfsr);
   assign sig_nxt  = shift16(signature) ^ {13'b0, dut_out};

   // NOTE: every state register is assigned with <= so that all of them
   // sample the pre-edge values of each other, regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         lfsr      <= LFSR_SEED;
         num_lat   <= '0;
         drain_cnt <= '0;
         dut_in    <= 3'b000;
         busy      <= 1'b0;
         done      <= 1'b0;
         vec_cnt   <= '0;
         signature <= 16'h0000;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  lfsr      <= LFSR_SEED;
                  num_lat   <= num_vec;
                  vec_cnt   <= '0;
                  signature <= 16'h0000;
                  busy      <= 1'b1;
                  if (num_vec != '0) begin
                     state <= S_RUN;
                  end else begin
                     // Empty run: report completion immediately.
                     state <= S_DONE;
                     done  <= 1'b1;
                  end
               end
            end

            S_RUN: begin
               if (!pause) begin
                  lfsr      <= lfsr_nxt;
                  dut_in    <= lfsr_nxt[2:0];
                  vec_cnt   <= vec_cnt + CNT_W'(1);
                  signature <= sig_nxt;
                  // Leave on the edge that applies the last vector; since
                  // the counter stops at num_lat it can never wrap.
                  if (vec_cnt + CNT_W'(1) == num_lat) begin
                     state     <= S_DRAIN;
                     drain_cnt <= '0;
                  end
               end
            end

            S_DRAIN: begin
               // The last vector stays on dut_in for its full cycle; zeros
               // follow from the first drain edge onward.
               dut_in    <= 3'b000;
               signature <= sig_nxt;
               if (drain_cnt == DRAIN_LAST) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + DW'(1);
               end
            end

            S_DONE: begin
               state <= S_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end

            default: begin
               state <= S_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
